hsv2rgb: RTL and testbench
==========================

# hsv2rgb

Pixel-stream HSV-to-RGB converter, the inverse of the team's RGB-to-HSV front end. It accepts the packed {hue, saturation, value} stream with its hs/vs/de timing and reconstructs 8-bit-per-channel RGB. Saturation is chroma (max − min) and value is max, so conversion needs no divider. It sits after HSV-domain processing, such as thresholding or colour substitution, and before display or frame transmission, in a fixed 3-stage pipeline with timing signals delayed to match.

## Interface
- BLANK_ZERO, default 1: when 1, `rgb` is forced to 24'h000000 on any output cycle where `rgb_de` is 0; when 0, blanking-period data passes through converted.
- clk  input  1  pixel clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- hsv_hs  input  1  horizontal sync accompanying `hsv`
- hsv_vs  input  1  vertical sync accompanying `hsv`
- hsv_de  input  1  data enable accompanying `hsv`
- hsv  input  24  {hue[23:16], saturation[15:8], value[7:0]}
- rgb_hs  output  1  `hsv_hs` delayed 3 cycles
- rgb_vs  output  1  `hsv_vs` delayed 3 cycles
- rgb_de  output  1  `hsv_de` delayed 3 cycles
- rgb  output  24  {red[23:16], green[15:8], blue[7:0]}, registered

## Operation
- Names: H = hue, C = saturation (chroma), V = value.
- Hue circle is 0..191, six sectors of 32 codes each.
  - Wrap rule: H ≥ 192 uses H − 192.
  - Sector s = Hw[7:5] (0..5); fraction f = Hw[4:0].
- Stage 1 (register):
  - mn = (C ≤ V) ? V − C : 0.
  - Ce = V − mn; this clamps chroma when C > V.
  - Register V, mn, Ce, s, f.
- Stage 2 (register): p = Ce × f, an unsigned 13-bit product. Carry V, mn, s.
- Stage 3 (register):
  - x = p[12:5]. This is ≤ Ce, so there is no overflow.
  - rise = mn + x; fall = V − x. Both stay within 0..255; no saturation logic is needed.
  - Channel selection by sector:
    - s0: R=V, G=rise, B=mn
    - s1: R=fall, G=V, B=mn
    - s2: R=mn, G=V, B=rise
    - s3: R=mn, G=fall, B=V
    - s4: R=rise, G=mn, B=V
    - s5: R=V, G=mn, B=fall
- Zero inputs: C = 0 gives R=G=B=V (grey). H = 0 gives (V, mn, mn), so hue-ignored streams from the RGB-to-HSV block reconstruct as red-tinted.
- Blanking: with BLANK_ZERO=1, the stage-3 register loads 0 whenever the stage-2 copy of de is 0.
- Timing signals: hs/vs/de pass through a 3-deep shift register with no modification.
- Every input is processed on every clock. There is no backpressure and no stall.

## Timing
- Latency is exactly 3 clocks. An input sampled on edge n appears on `rgb`/`rgb_*` after edge n+3.
- Throughput: one pixel per clock, sustained.
- Reset:
  - On rst assertion, all pipeline and sync registers clear immediately (asynchronously).
  - Reset values: `rgb` = 24'h000000, `rgb_hs` = 0, `rgb_vs` = 0, `rgb_de` = 0.
- Reset mid-line: outputs drop to zero while rst is high. After release, the first valid output is the pixel sampled on the first edge with rst low, emerging 3 edges later. Intervening outputs come from cleared registers (all zero).
- Data and sync alignment is invariant: the `rgb` value and the sync bits on any cycle always derive from the same input cycle.
- Sector boundaries:
  - f = 31 at s0 yields G = mn + (Ce·31 >> 5), which is below V.
  - The next code, H = 32 (s1, f = 0), yields G = V. This is continuous within rounding.
- Hue wrap boundary: H = 191 and H = 192 must produce s5/f31 and s0/f0 respectively.

## Test plan
- Reset, then reset mid-stream:
  - Hold rst for 5 cycles with random hsv → all outputs 0.
  - Release, drive hsv = 24'h00FFFF with de = 1 → rgb = 24'hFF0000, de = 1, exactly 3 edges later.
  - Assert rst asynchronously mid-line → all outputs 0 before the next edge.
- Sector interior: H=16, C=200, V=240 → mn=40, x=100 → rgb = 24'hF08C28. Also H=80, same C/V → s2, f=16 → rgb = 24'h28F08C.
- Hue wrap and clamp:
  - H=200, C=200, V=240 → treated as H=8, x=50 → rgb = 24'hF05A28.
  - H=64, C=100, V=60 → mn=0, Ce=60 → rgb = 24'h003C00.
- Grey and the hue-ignored path:
  - H=0, C=0, V=128 → 24'h808080.
  - H=0, C=255, V=255 → 24'hFF0000.
- Sync alignment and blanking:
  - Drive hs/vs pulses of 1–4 cycles with de toggling → each output timing bit matches its input delayed 3 cycles.
  - BLANK_ZERO=1: rgb = 0 whenever rgb_de = 0.
  - BLANK_ZERO=0: blank-cycle hsv converts normally.
- Sweep: for all 256 H with C=255, V=255, compare against a reference model of this spec (including the wrap rule). Check that R, G and B never exceed V and never fall below mn.

Source files
------------

// File: rtl/hsv2rgb.sv
// Pixel-stream HSV-to-RGB converter: 3-stage pipeline, hs/vs/de delayed to match.
// hsv = {hue, chroma, value}; rgb = {red, green, blue}; no divider needed.
module hsv2rgb #(
  parameter bit BLANK_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsv_hs,
  input  logic        hsv_vs,
  input  logic        hsv_de,
  input  logic [23:0] hsv,
  output logic        rgb_hs,
  output logic        rgb_vs,
  output logic        rgb_de,
  output logic [23:0] rgb
);

  // Six 32-code sectors of the 0..191 hue circle, named by the rising/falling edge pair.
  typedef enum logic [2:0] {
    SEC_RED_YEL = 3'd0,
    SEC_YEL_GRN = 3'd1,
    SEC_GRN_CYN = 3'd2,
    SEC_CYN_BLU = 3'd3,
    SEC_BLU_MAG = 3'd4,
    SEC_MAG_RED = 3'd5
  } sector_e;

  logic [7:0] h_in, c_in, v_in;
  logic [7:0] hue_wrapped;
  logic [7:0] mn_d, ce_d;

  assign h_in = hsv[23:16];
  assign c_in = hsv[15:8];
  assign v_in = hsv[7:0];

  assign hue_wrapped = (h_in >= 8'd192) ? (h_in - 8'd192) : h_in;
  // A chroma larger than value would push min below zero; clamp min to 0 and shrink chroma.
  assign mn_d = (c_in <= v_in) ? (v_in - c_in) : 8'd0;
  assign ce_d = v_in - mn_d;

  // Stage 1 registers
  logic [7:0] s1_v, s1_mn, s1_ce;
  logic [2:0] s1_sec;
  logic [4:0] s1_f;

  // Stage 2 registers
  logic [12:0] s2_p;
  logic [7:0]  s2_v, s2_mn;
  logic [2:0]  s2_sec;

  // Sync delay lines; bit k holds the value after stage k+1.
  logic [2:0] hs_sr, vs_sr, de_sr;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the previous stage's pre-edge value; blocking here would collapse the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= '0;
      s1_mn  <= '0;
      s1_ce  <= '0;
      s1_sec <= '0;
      s1_f   <= '0;
    end else begin
      s1_v   <= v_in;
      s1_mn  <= mn_d;
      s1_ce  <= ce_d;
      s1_sec <= hue_wrapped[7:5];
      s1_f   <= hue_wrapped[4:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_p   <= '0;
      s2_v   <= '0;
      s2_mn  <= '0;
      s2_sec <= '0;
    end else begin
      s2_p   <= 13'(s1_ce) * 13'(s1_f);
      s2_v   <= s1_v;
      s2_mn  <= s1_mn;
      s2_sec <= s1_sec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_sr <= '0;
      vs_sr <= '0;
      de_sr <= '0;
    end else begin
      hs_sr <= {hs_sr[1:0], hsv_hs};
      vs_sr <= {vs_sr[1:0], hsv_vs};
      de_sr <= {de_sr[1:0], hsv_de};
    end
  end

  // Stage 3: ramp value x never exceeds chroma, so rise/fall stay inside [mn, V].
  logic [7:0]  x, rise, fall;
  logic [7:0]  r_d, g_d, b_d;
  logic [23:0] rgb_d;

  assign x    = s2_p[12:5];
  assign rise = s2_mn + x;
  assign fall = s2_v - x;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    r_d = s2_v;
    g_d = rise;
    b_d = s2_mn;
    case (sector_e'(s2_sec))
      SEC_RED_YEL: begin r_d = s2_v;  g_d = rise;  b_d = s2_mn; end
      SEC_YEL_GRN: begin r_d = fall;  g_d = s2_v;  b_d = s2_mn; end
      SEC_GRN_CYN: begin r_d = s2_mn; g_d = s2_v;  b_d = rise;  end
      SEC_CYN_BLU: begin r_d = s2_mn; g_d = fall;  b_d = s2_v;  end
      SEC_BLU_MAG: begin r_d = rise;  g_d = s2_mn; b_d = s2_v;  end
      SEC_MAG_RED: begin r_d = s2_v;  g_d = s2_mn; b_d = fall;  end
      default:     begin r_d = s2_v;  g_d = rise;  b_d = s2_mn; end
    endcase
    rgb_d = {r_d, g_d, b_d};
    if (BLANK_ZERO && !de_sr[1]) rgb_d = 24'h000000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rgb <= '0;
    else     rgb <= rgb_d;
  end

  assign rgb_hs = hs_sr[2];
  assign rgb_vs = vs_sr[2];
  assign rgb_de = de_sr[2];

endmodule

// File: tb/tb_hsv2rgb.sv
// Self-checking bench for hsv2rgb: directed vector table, reset/sync sequences, hue sweep.
// Two instances share the inputs: one blanks inactive cycles, one converts them.
module tb_hsv2rgb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsv_hs = 1'b0, hsv_vs = 1'b0, hsv_de = 1'b0;
  logic [23:0] hsv = '0;
  logic        b_hs, b_vs, b_de, p_hs, p_vs, p_de;
  logic [23:0] b_rgb, p_rgb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hsv2rgb #(.BLANK_ZERO(1'b1)) dut_blank (
    .clk(clk), .rst(rst), .hsv_hs(hsv_hs), .hsv_vs(hsv_vs), .hsv_de(hsv_de), .hsv(hsv),
    .rgb_hs(b_hs), .rgb_vs(b_vs), .rgb_de(b_de), .rgb(b_rgb)
  );

  hsv2rgb #(.BLANK_ZERO(1'b0)) dut_pass (
    .clk(clk), .rst(rst), .hsv_hs(hsv_hs), .hsv_vs(hsv_vs), .hsv_de(hsv_de), .hsv(hsv),
    .rgb_hs(p_hs), .rgb_vs(p_vs), .rgb_de(p_de), .rgb(p_rgb)
  );

  typedef struct {
    logic [23:0] hsv;
    logic [23:0] rgb;
  } vec_t;

  typedef struct {
    logic        hs, vs, de;
    logic [23:0] hsv;
  } in_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference conversion written straight from the colour-wheel definition.
  function automatic logic [23:0] ref_rgb(input logic [23:0] p);
    int h, c, v, mn, ce, hw, s, f, x, r, g, b;
    h  = int'(p[23:16]);
    c  = int'(p[15:8]);
    v  = int'(p[7:0]);
    hw = (h >= 192) ? h - 192 : h;
    mn = (c <= v) ? v - c : 0;
    ce = v - mn;
    s  = hw / 32;
    f  = hw % 32;
    x  = (ce * f) / 32;
    case (s)
      0: begin r = v;      g = mn + x; b = mn;     end
      1: begin r = v - x;  g = v;      b = mn;     end
      2: begin r = mn;     g = v;      b = mn + x; end
      3: begin r = mn;     g = v - x;  b = v;      end
      4: begin r = mn + x; g = mn;     b = v;      end
      default: begin r = v; g = mn;    b = v - x;  end
    endcase
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  vec_t vecs[15];
  in_t  hist[64];

  initial begin
    // Hand-computed directed vectors: {hue, chroma, value} -> {R, G, B}
    vecs[0]  = '{24'h00FFFF, 24'hFF0000};  // hue-ignored full colour
    vecs[1]  = '{24'h10C8F0, 24'hF08C28};  // s0 f16
    vecs[2]  = '{24'h50C8F0, 24'h28F08C};  // s2 f16
    vecs[3]  = '{24'hC8C8F0, 24'hF05A28};  // H=200 wraps to 8
    vecs[4]  = '{24'h40643C, 24'h003C00};  // C > V clamp
    vecs[5]  = '{24'h000080, 24'h808080};  // grey
    vecs[6]  = '{24'h1FFFFF, 24'hFFF700};  // s0 f31
    vecs[7]  = '{24'h20FFFF, 24'hFFFF00};  // s1 f0
    vecs[8]  = '{24'hBFFFFF, 24'hFF0008};  // H=191 s5 f31
    vecs[9]  = '{24'hC0FFFF, 24'hFF0000};  // H=192 s0 f0
    vecs[10] = '{24'h60FFFF, 24'h00FFFF};  // s3 f0
    vecs[11] = '{24'h80FFFF, 24'h0000FF};  // s4 f0
    vecs[12] = '{24'hA0FFFF, 24'hFF00FF};  // s5 f0
    vecs[13] = '{24'hFFFFFF, 24'h08FF00};  // H=255 wraps to s1 f31
    vecs[14] = '{24'h303264, 24'h4B6432};  // s1 f16, mn=50

    // Reset held for 5 cycles with random input
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      hsv = 24'($urandom); hsv_de = 1'b1; hsv_hs = 1'b1; hsv_vs = 1'b1;
      check("reset_hold_blank", {b_hs, b_vs, b_de, b_rgb}, 27'h0);
      check("reset_hold_pass",  {p_hs, p_vs, p_de, p_rgb}, 27'h0);
    end

    // Release and drive one pixel; it must appear exactly 3 edges later
    @(negedge clk);
    rst = 1'b0; hsv = 24'h00FFFF; hsv_de = 1'b1; hsv_hs = 1'b0; hsv_vs = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      hsv = 24'h000000; hsv_de = 1'b0;
      if (i < 3) check("post_reset_cleared", {b_de, b_rgb}, 25'h0);
      else       check("post_reset_first", {b_de, b_rgb}, {1'b1, 24'hFF0000});
    end

    // Asynchronous reset in the middle of an active line
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hsv = 24'h10C8F0; hsv_de = 1'b1; hsv_hs = 1'b1; hsv_vs = 1'b1;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_blank", {b_hs, b_vs, b_de, b_rgb}, 27'h0);
    check("async_reset_pass",  {p_hs, p_vs, p_de, p_rgb}, 27'h0);
    @(negedge clk);
    rst = 1'b0; hsv_hs = 1'b0; hsv_vs = 1'b0;

    // Directed table, streamed back-to-back
    for (int i = 0; i < 15 + 3; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        check($sformatf("vec%0d_rgb", i - 3), b_rgb, vecs[i - 3].rgb);
        check($sformatf("vec%0d_de", i - 3), b_de, 1'b1);
      end
      if (i < 15) begin hsv = vecs[i].hsv; hsv_de = 1'b1; end
      else        begin hsv = 24'h0;       hsv_de = 1'b0; end
    end

    // Sync alignment and blanking with hs/vs pulses of 1-4 cycles
    begin
      int hs_run, vs_run;
      hs_run = 1; vs_run = 2;
      for (int i = 0; i < 64 + 3; i++) begin
        @(negedge clk);
        if (i >= 3) begin
          check("sync_blank", {b_hs, b_vs, b_de}, {hist[i-3].hs, hist[i-3].vs, hist[i-3].de});
          check("sync_pass",  {p_hs, p_vs, p_de}, {hist[i-3].hs, hist[i-3].vs, hist[i-3].de});
          check("blank_rgb", b_rgb, hist[i-3].de ? ref_rgb(hist[i-3].hsv) : 24'h0);
          check("pass_rgb",  p_rgb, ref_rgb(hist[i-3].hsv));
        end
        if (i < 64) begin
          if (--hs_run == 0) begin hsv_hs = ~hsv_hs; hs_run = int'($urandom_range(1, 4)); end
          if (--vs_run == 0) begin hsv_vs = ~hsv_vs; vs_run = int'($urandom_range(1, 4)); end
          hsv_de = 1'($urandom);
          hsv    = 24'($urandom);
          hist[i] = '{hsv_hs, hsv_vs, hsv_de, hsv};
        end
      end
    end

    // Full hue sweep at C=255, V=255 (mn=0)
    hsv_hs = 1'b0; hsv_vs = 1'b0;
    for (int i = 0; i < 256 + 3; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        logic [23:0] exp_rgb;
        exp_rgb = ref_rgb({8'(i - 3), 16'hFFFF});
        check($sformatf("sweep_h%0d", i - 3), b_rgb, exp_rgb);
        // Channels stay within [mn, V] = [0, 255]; the lower bound is trivial here,
        // so also require at least one channel at V and one at mn.
        check($sformatf("sweep_bounds_h%0d", i - 3),
              {31'd0, (b_rgb[23:16] == 8'hFF || b_rgb[15:8] == 8'hFF || b_rgb[7:0] == 8'hFF) &&
                      (b_rgb[23:16] == 8'h00 || b_rgb[15:8] == 8'h00 || b_rgb[7:0] == 8'h00)},
              32'd1);
      end
      if (i < 256) begin hsv = {8'(i), 16'hFFFF}; hsv_de = 1'b1; end
      else         begin hsv = 24'h0;             hsv_de = 1'b0; end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
